// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential signed/unsigned shift-and-add multiplier, one
//               WIDTH+1-bit adder reused over WIDTH iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 validity,
    output logic [2*WIDTH-1:0]   result
);

    localparam int              c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CW-1:0]      r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;      // {acc_hi, multiplier being shifted out}
    logic                 r_sign;
    logic                 r_valid;
    logic [2*WIDTH-1:0]   r_result;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod_neg;

    // Magnitude of the most negative value wraps to itself, read as unsigned.
    assign w_mag_a    = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_mag_b    = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_prod_neg = -r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_ITERATE;
            ST_ITERATE: if (r_cnt == c_LAST) w_state_next = ST_FINISH;
            ST_FINISH:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign  <= (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]) & signed_mode;
                        r_mcand <= w_mag_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                ST_ITERATE: begin
                    // Carry lands in the top bit as the whole register shifts right.
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + c_ONE;
                end
                ST_FINISH: begin
                    r_result <= r_sign ? w_prod_neg : r_acc;
                    r_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign validity = r_valid;
    assign result   = r_result;

endmodule
`default_nettype wire
